// File: rtl/fade_sequencer_if.sv
// Control/status bundle between the animation controller and the fade sequencer.
// The master drives requests; the slave (sequencer) returns the level and status.
interface fade_sequencer_if;
    logic       start;
    logic       stop;
    logic [1:0] mode;
    logic       repeat_en;
    logic [3:0] duty_cycle;
    logic       busy;
    logic       cycle_done;

    modport master (
        output start, stop, mode, repeat_en,
        input  duty_cycle, busy, cycle_done
    );

    modport slave (
        input  start, stop, mode, repeat_en,
        output duty_cycle, busy, cycle_done
    );
endinterface

// File: rtl/fade_sequencer.sv
// Brightness-level animator feeding the LED PWM stage; steps align to PWM periods.
// Define FADE_GAMMA_EN to drive duty_cycle through a perceptual brightness map.
module fade_sequencer #(
    parameter int unsigned PWM_DIV         = 20,
    parameter int unsigned STEPS_PER_LEVEL = 4,
    parameter int unsigned HOLD_STEPS      = 8,
    parameter int unsigned MAX_LEVEL       = 10
) (
    input  logic             clk,
    input  logic             rst,
    fade_sequencer_if.slave  ctrl
);

    localparam int unsigned PER_W  = $clog2(PWM_DIV + 1);
    localparam int unsigned STP_W  = $clog2(STEPS_PER_LEVEL + 1);
    localparam int unsigned HOLD_W = $clog2(HOLD_STEPS + 1);

    localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(PWM_DIV - 1);
    localparam logic [STP_W-1:0]  STP_LAST  = STP_W'(STEPS_PER_LEVEL - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_STEPS - 1);
    localparam logic [3:0]        MAX_LVL   = 4'(MAX_LEVEL);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UP,
        S_HIGH,
        S_DOWN,
        S_LOW
    } state_t;

    typedef enum logic [1:0] {
        M_BREATHE  = 2'b00,
        M_SAWTOOTH = 2'b01,
        M_BLINK    = 2'b10,
        M_CONST    = 2'b11
    } mode_t;

    state_t            state_q, state_d;
    mode_t             mode_q, mode_d;
    logic [3:0]        level_q, level_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [PER_W-1:0]  per_q, per_d;
    logic [STP_W-1:0]  stp_q, stp_d;
    logic [3:0]        duty_q, duty_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic per_wrap;
    logic stp_wrap;
    logic tick;

    function automatic logic [3:0] shape(input logic [3:0] lvl);
`ifdef FADE_GAMMA_EN
        logic [3:0] res;
        case (lvl)
            4'd0, 4'd1, 4'd2: res = 4'd0;
            4'd3, 4'd4:       res = 4'd1;
            4'd5:             res = 4'd2;
            4'd6:             res = 4'd3;
            4'd7:             res = 4'd5;
            4'd8:             res = 4'd6;
            4'd9:             res = 4'd8;
            4'd10:            res = 4'd10;
            default:          res = MAX_LVL;
        endcase
        return res;
`else
        return lvl;
`endif
    endfunction

    assign per_wrap = (per_q == PER_LAST);
    assign stp_wrap = (stp_q == STP_LAST);
    assign tick     = (state_q != S_IDLE) && per_wrap && stp_wrap;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned and infers a latch.
        state_d = state_q;
        mode_d  = mode_q;
        level_d = level_q;
        hold_d  = hold_q;
        done_d  = 1'b0;
        per_d   = '0;
        stp_d   = '0;

        // Timebase free-runs only while an animation is active.
        if (state_q != S_IDLE) begin
            per_d = per_wrap ? '0 : per_q + PER_W'(1);
            stp_d = per_wrap ? (stp_wrap ? '0 : stp_q + STP_W'(1)) : stp_q;
        end

        case (state_q)
            S_IDLE: begin
                level_d = '0;
                hold_d  = '0;
                if (ctrl.start) begin
                    mode_d = mode_t'(ctrl.mode);
                    if (mode_t'(ctrl.mode) == M_BREATHE || mode_t'(ctrl.mode) == M_SAWTOOTH) begin
                        state_d = S_UP;
                    end else begin
                        state_d = S_HIGH;
                        level_d = MAX_LVL;
                    end
                end
            end

            S_UP: begin
                if (tick) begin
                    if (level_q >= MAX_LVL - 4'd1) begin
                        level_d = MAX_LVL;
                        hold_d  = '0;
                        state_d = S_HIGH;
                    end else begin
                        level_d = level_q + 4'd1;
                    end
                end
            end

            S_HIGH: begin
                if (tick && mode_q != M_CONST) begin
                    if (hold_q == HOLD_LAST) begin
                        hold_d = '0;
                        if (mode_q == M_BREATHE) begin
                            state_d = S_DOWN;
                        end else begin
                            state_d = S_LOW;
                            level_d = '0;
                        end
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
            end

            S_DOWN: begin
                if (tick) begin
                    if (level_q <= 4'd1) begin
                        level_d = '0;
                        hold_d  = '0;
                        state_d = S_LOW;
                    end else begin
                        level_d = level_q - 4'd1;
                    end
                end
            end

            S_LOW: begin
                if (tick) begin
                    if (hold_q == HOLD_LAST) begin
                        done_d = 1'b1;
                        hold_d = '0;
                        if (!ctrl.repeat_en) begin
                            state_d = S_IDLE;
                            level_d = '0;
                        end else if (mode_q == M_BREATHE || mode_q == M_SAWTOOTH) begin
                            state_d = S_UP;
                            level_d = '0;
                        end else begin
                            state_d = S_HIGH;
                            level_d = MAX_LVL;
                        end
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                level_d = '0;
                hold_d  = '0;
            end
        endcase

        // Abort overrides everything, including a simultaneous start.
        if (ctrl.stop) begin
            state_d = S_IDLE;
            level_d = '0;
            hold_d  = '0;
            per_d   = '0;
            stp_d   = '0;
            done_d  = 1'b0;
        end
    end

    assign duty_d = shape(level_d);
    assign busy_d = (state_d != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            mode_q  <= M_BREATHE;
            level_q <= '0;
            hold_q  <= '0;
            per_q   <= '0;
            stp_q   <= '0;
            duty_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
            state_q <= state_d;
            mode_q  <= mode_d;
            level_q <= level_d;
            hold_q  <= hold_d;
            per_q   <= per_d;
            stp_q   <= stp_d;
            duty_q  <= duty_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ctrl.duty_cycle = duty_q;
    assign ctrl.busy       = busy_q;
    assign ctrl.cycle_done = done_q;

endmodule

// File: doc/fade_sequencer.md
Name: fade_sequencer

Overview:
- Upstream of the LED PWM stage: generates the 4-bit brightness level (0..MAX_LEVEL) that the PWM consumes as duty_cycle.
- Steps the level in time to produce breathe, sawtooth, blink or constant-on animations.
- All steps are aligned to PWM period boundaries, derived from PWM_DIV.

Parameters:
- PWM_DIV, 20: clocks per PWM period; must equal the PWM stage's divider.
- STEPS_PER_LEVEL, 4: PWM periods per level step (step tick).
- HOLD_STEPS, 8: step ticks spent in HIGH and in LOW states (≥1).
- MAX_LEVEL, 10: top duty level, ≤15.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-clock request to begin an animation; ignored while busy
- stop  in  1  synchronous abort to IDLE; highest priority
- mode  in  2  00 breathe, 01 sawtooth, 10 blink, 11 constant-on; latched on accepted start
- repeat_en  in  1  sampled at end of LOW hold; 1 restarts the cycle, 0 returns to IDLE
- duty_cycle  out  4  registered level to the PWM stage
- busy  out  1  high in any state other than IDLE
- cycle_done  out  1  one-clock pulse at end of each completed LOW hold

Behaviour:
- Reset values: duty_cycle=0, busy=0, cycle_done=0, state=IDLE. Internal counters, level, hold count and latched mode are also cleared.
- Timebase:
  - per_cnt runs 0..PWM_DIV-1 and wraps.
  - stp_cnt advances on each per_cnt wrap and runs 0..STEPS_PER_LEVEL-1.
  - tick is asserted when both counters are at their terminal values, i.e. one tick every PWM_DIV*STEPS_PER_LEVEL clocks (80 by default).
  - The timebase runs only while busy and is cleared on an accepted start, so the first tick comes exactly 80 clocks after start.
- All state, level and output updates are registered. duty_cycle changes on the clock edge where tick is high.
- States are IDLE, UP, HIGH, DOWN, LOW.
- IDLE:
  - level=0.
  - On start (when stop=0), latch mode and go to a start state:
    - modes 00 and 01: UP with level 0;
    - modes 10 and 11: HIGH with level=MAX_LEVEL and hold count 0. duty_cycle=MAX_LEVEL on the next clock.
- UP: on each tick, level+1. The tick that raises level to MAX_LEVEL also enters HIGH with hold count 0.
- HIGH:
  - Mode 11: remain in HIGH indefinitely; the hold counter does not count.
  - Other modes: the hold counter increments on each tick. On the tick where it equals HOLD_STEPS-1:
    - mode 00: go to DOWN (level stays MAX_LEVEL);
    - modes 01 and 10: go to LOW with level=0.
- DOWN: on each tick, level-1. The tick that lowers level to 0 enters LOW with hold count 0.
- LOW:
  - Holds HOLD_STEPS ticks.
  - On the final tick, cycle_done=1 for that one clock.
  - If repeat_en=1: modes 00 and 01 go to UP with level 0; mode 10 goes to HIGH with level=MAX_LEVEL.
  - If repeat_en=0: go to IDLE.
- Level width and bounds: level is 4 bits and never leaves 0..MAX_LEVEL. There is no wrap; UP and DOWN stop at the bounds.
- Default cycle lengths:
  - breathe: 10+8+10+8 = 36 ticks = 2880 clks;
  - sawtooth: 10+8+8 = 26 ticks;
  - blink: 8+8 = 16 ticks.
- stop:
  - From any state, next clock: state=IDLE, duty_cycle=0, busy=0, timebase cleared, no cycle_done.
  - If stop and start arrive in the same cycle, stop wins.
- Changes to mode while busy have no effect until the next accepted start.
- Asynchronous rst mid-animation: immediate return to all reset values.

Optional Feature:
- Macro: FADE_GAMMA_EN.
- Defined: duty_cycle is the registered perceptual map of level, for level 0..10 → 0,0,0,1,1,2,3,5,6,8,10. Levels above 10 map to MAX_LEVEL. Timing is identical.
- Undefined: duty_cycle = level.

Test Plan:
- rst held, then released; mode=00, start pulse:
  - busy=1 next clk; duty_cycle=0; duty_cycle=1 at clk 80 after start, 10 at clk 800;
  - DOWN begins at 1440; 0 reached at 2240; cycle_done pulses at 2880; busy=0 after (repeat_en=0).
- mode=10, repeat_en=1, start → duty_cycle=10 for 640 clks, then 0 for 640 clks, repeating; cycle_done every 1280 clks.
- mode=11, start → duty_cycle=10 steady for 10000 clks, no cycle_done; stop → duty_cycle=0, busy=0 next clk.
- Mid-UP at level 5, assert start and stop together → IDLE, duty 0; a later start restarts from level 0 with first tick 80 clks later.
- mode=01 with repeat_en=1, then drop repeat_en during HIGH → completes LOW, cycle_done once, IDLE; a mode change during run is ignored.
- FADE_GAMMA_EN defined, mode=00 → duty_cycle sequence 0,0,0,1,1,2,3,5,6,8,10 on UP ticks; async rst at level 7 → all outputs 0 immediately.
